// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Holds the FSM states, opcodes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [2:0] SRCB_REG  = 3'b000;
  localparam logic [2:0] SRCB_4    = 3'b001;
  localparam logic [2:0] SRCB_SEXT = 3'b010;
  localparam logic [2:0] SRCB_SHL2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT = 3'b100;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences one instruction in 2-5 cycles.
// In: clk, rst, op, zero. Out: write enables, mux selects, alu_op, done/illegal.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);

  state_t r_state;
  state_t w_next;

  logic w_pc_en, w_mem_write, w_ir_write;
  logic w_reg_write, w_done, w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW), (op == OP_SW):     w_next = S_MEMADR;
          (op == OP_RTYPE):                 w_next = S_REXEC;
          (op == OP_BEQ), (op == OP_BNE):   w_next = S_BRANCH;
          (op == OP_ADDI), (op == OP_ANDI),
          (op == OP_ORI):                   w_next = S_IEXEC;
          (op == OP_J):                     w_next = S_JUMP;
          (op == OP_JAL):                   w_next = S_JAL;
          default:                          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_REXEC:  w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_en     = 1'b0;
    iord        = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    reg_dst     = RD_RT;
    mem_to_reg  = WB_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PCS_ALU;
    alu_op      = ALU_ADD;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        alu_src_b  = SRCB_4;
        w_pc_en    = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = SRCB_SHL2;
        unique case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ANDI, OP_ORI, OP_J, OP_JAL: ;
          default: begin
            w_illegal = 1'b1;
            w_done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = WB_MDR;
        w_done      = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        w_done      = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        reg_dst     = RD_RD;
        w_done      = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        unique case (op)
          OP_ANDI: begin
            alu_src_b = SRCB_ZEXT;
            alu_op    = ALU_AND;
          end
          OP_ORI: begin
            alu_src_b = SRCB_ZEXT;
            alu_op    = ALU_OR;
          end
          default: alu_src_b = SRCB_SEXT;
        endcase
      end
      S_IWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCS_OUT;
        // beq and bne differ only in op[0]; bne takes on ~zero
        w_pc_en   = zero ^ op[0];
        w_done    = 1'b1;
      end
      S_JUMP: begin
        pc_src  = PCS_JUMP;
        w_pc_en = 1'b1;
        w_done  = 1'b1;
      end
      S_JAL: begin
        pc_src      = PCS_JUMP;
        w_pc_en     = 1'b1;
        w_reg_write = 1'b1;
        reg_dst     = RD_RA;
        mem_to_reg  = WB_PC;
        w_done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by rst so nothing writes while reset is held,
  // even though the state already reads FETCH.
  assign pc_en      = w_pc_en & ~rst;
  assign mem_write  = w_mem_write & ~rst;
  assign ir_write   = w_ir_write & ~rst;
  assign reg_write  = w_reg_write & ~rst;
  assign instr_done = w_done & ~rst;
  assign illegal    = w_illegal & ~rst;

endmodule
